dmem_load_ctrl: RTL and testbench
=================================

// Module: dmem_load_ctrl
// PURPOSE
//  Sequences the data-memory port between an external host loader and riscv_cpu.
//  - Holds the CPU in reset while the host preloads or reads back data memory.
//  - Releases the CPU on start and runs it until halt or a cycle budget expires.
//  - Re-freezes the CPU so the host can read back results.
//  - Sits between the host interface, riscv_cpu and data_mem; replaces the ad-hoc reset-gated muxes.
// PARAMETERS
//  ADDR_W      32  data-memory address width
//  DATA_W      32  data word width
//  CNT_W       16  width of load_count (saturating)
//  MAX_CYCLES  0   RUN cycle budget; 0 = unlimited
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-low reset
//  ext_req      in   1       host access request
//  ext_we       in   1       host write (1) / read (0)
//  ext_addr     in   ADDR_W  host byte address, word aligned
//  ext_wdata    in   DATA_W  host write data
//  ext_gnt      out  1       host access accepted this cycle
//  ext_rdata    out  DATA_W  host read data
//  ext_rvalid   out  1       ext_rdata valid (1-cycle pulse)
//  start        in   1       level-sampled; IDLE/HALT -> RUN
//  halt         in   1       level-sampled; RUN -> HALT
//  cpu_reset    out  1       active-high reset to riscv_cpu
//  cpu_memwrite in   1       CPU store strobe
//  cpu_adr      in   ADDR_W  CPU data address
//  cpu_wdata    in   DATA_W  CPU store data
//  mem_we       out  1       to data_mem write enable
//  mem_adr      out  ADDR_W  to data_mem address
//  mem_wdata    out  DATA_W  to data_mem write data
//  mem_rdata    in   DATA_W  from data_mem (combinational read)
//  state        out  2       IDLE=0, RUN=1, HALT=2
//  load_count   out  CNT_W   accepted host writes, saturating
//  run_cycles   out  32      cycles spent in current RUN
//  err          out  1       sticky: misaligned host request seen
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - state=IDLE, cpu_reset=1, ext_rvalid=0, ext_rdata=0.
//  - load_count=0, run_cycles=0, err=0.
//  - Memory contents untouched; reset mid-RUN aborts immediately to IDLE.
//  Ownership:
//  - Host owns the port in IDLE/HALT; CPU owns it in RUN.
//  - Mux is combinational on registered state.
//  - Host owner: mem_adr=ext_addr, mem_wdata=ext_wdata, mem_we=ext_req&ext_we&aligned.
//  - CPU owner: mem_adr=cpu_adr, mem_wdata=cpu_wdata, mem_we=cpu_memwrite.
//  ext_gnt:
//  - Combinational: ext_req & aligned & (state!=RUN); never 1 in RUN.
//  - aligned = (ext_addr[1:0]==0).
//  - Misaligned request: no gnt, no write, err<=1.
//  Host reads:
//  - Granted read: ext_rdata<=mem_rdata, ext_rvalid<=1 next cycle (1-cycle latency).
//  - Otherwise ext_rvalid<=0.
//  load_count: +1 per granted write, saturates at all-ones.
//  FSM:
//  - IDLE --start--> RUN.
//  - RUN --halt | (MAX_CYCLES!=0 & run_cycles==MAX_CYCLES-1)--> HALT.
//  - HALT --start--> RUN.
//  - start ignored in RUN; halt ignored in IDLE/HALT.
//  - start and halt together in RUN -> HALT.
//  Same-cycle host access and start: access completes that cycle, then RUN.
//  cpu_reset: registered, equals (next_state!=RUN); 0 from the first RUN cycle, 1 from the first HALT cycle.
//  run_cycles:
//  - Cleared on entry to RUN; +1 each RUN cycle.
//  - Holds its value in HALT/IDLE; wraps at 2^32.
// STRUCTURE
//  - dmem_ctrl_defs.vh (shared include): state encodings ST_IDLE/ST_RUN/ST_HALT, width defaults.
//  - Sub-module sat_counter (WIDTH param, clr/inc, saturating) for load_count.
//  - FSM, mux and run counter inline.
// TESTING
//  1 Host writes 0xDEADBEEF@0x10 and 0x12345678@0x14 in IDLE -> mem_we=1 both cycles,
//    ext_gnt=1, load_count=2, cpu_reset=1.
//  2 Host read @0x10 in IDLE -> next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF.
//  3 start pulse -> next cycle state=RUN, cpu_reset=0; host req gets ext_gnt=0,
//    mem_adr tracks cpu_adr, cpu_memwrite drives mem_we.
//  4 MAX_CYCLES=8 -> HALT entered exactly 8 cycles after RUN entry;
//    run_cycles=8, cpu_reset=1, host read of a CPU-stored word returns the CPU value.
//  5 ext_addr=0x13 write -> ext_gnt=0, mem_we=0, err=1 and stays 1 until reset.
//  6 reset low mid-RUN -> next cycle state=IDLE, cpu_reset=1, counters 0,
//    previously written memory word still reads back unchanged.

Source files
------------

// File: rtl/dmem_load_ctrl_pkg.sv
// dmem_load_ctrl_pkg: state encodings, width defaults and the alignment helper shared by the loader controller.
package dmem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_load_ctrl_sat_counter.sv
// dmem_load_ctrl_sat_counter: synchronous-clear up-counter that sticks at all-ones.
//   clk   in  clock, rising edge
//   clr   in  synchronous clear, has priority over inc
//   inc   in  count enable
//   count out current value
module dmem_load_ctrl_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) count_q <= count_d;

    assign count = count_q;

endmodule

// File: rtl/dmem_load_ctrl.sv
// dmem_load_ctrl: arbitrates the data-memory port between a host loader and the CPU, holding the CPU in reset outside RUN.
//   clk, reset (sync, active-low)
//   host side : ext_req, ext_we, ext_addr, ext_wdata -> ext_gnt, ext_rdata, ext_rvalid
//   control   : start, halt -> state, cpu_reset, run_cycles
//   cpu side  : cpu_memwrite, cpu_adr, cpu_wdata
//   memory    : mem_we, mem_adr, mem_wdata -> mem_rdata (combinational read)
//   status    : load_count (saturating host-write count), err (sticky misaligned host request)
module dmem_load_ctrl
    import dmem_load_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    input  logic              start,
    input  logic              halt,
    output logic              cpu_reset,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  load_count,
    output logic [31:0]       run_cycles,
    output logic              err
);

    state_t            state_q, state_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic              err_q, err_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              aligned, host_own, rd_gnt, budget_hit;

    always_comb begin
        aligned      = word_aligned(ext_addr[1:0]);
        host_own     = state_q != ST_RUN;
        ext_gnt      = ext_req && aligned && host_own;
        mem_we       = host_own ? ext_req && ext_we && aligned : cpu_memwrite;
        mem_adr      = host_own ? ext_addr : cpu_adr;
        mem_wdata    = host_own ? ext_wdata : cpu_wdata;
        rd_gnt       = ext_gnt && !ext_we;
        // run_cycles counts completed RUN cycles, so the last budgeted cycle sees MAX_CYCLES-1
        budget_hit   = (MAX_CYCLES != 0) && (run_cycles_q == 32'(MAX_CYCLES - 1));
        state_d      = (state_q == ST_RUN) ? ((halt || budget_hit) ? ST_HALT : ST_RUN)
                                           : (start ? ST_RUN : state_q);
        run_cycles_d = (state_q == ST_RUN) ? run_cycles_q + 32'd1
                                           : ((state_d == ST_RUN) ? '0 : run_cycles_q);
        cpu_reset_d  = state_d != ST_RUN;
        err_d        = err_q || (ext_req && !aligned);
        ext_rvalid_d = rd_gnt;
        ext_rdata_d  = rd_gnt ? mem_rdata : ext_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cpu_reset_q  <= 1'b1;
            run_cycles_q <= '0;
            err_q        <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpu_reset_q  <= cpu_reset_d;
            run_cycles_q <= run_cycles_d;
            err_q        <= err_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    dmem_load_ctrl_sat_counter #(.WIDTH(CNT_W)) u_load_cnt (
        .clk   (clk),
        .clr   (!reset),
        .inc   (ext_gnt && ext_we),
        .count (load_count)
    );

    assign state      = state_q;
    assign cpu_reset  = cpu_reset_q;
    assign run_cycles = run_cycles_q;
    assign err        = err_q;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// tb_dmem_load_ctrl: directed and randomized checks of the loader controller against a behavioural model with its own memory image.
module tb_dmem_load_ctrl;

    localparam int MAXC = 8;
    localparam int CW   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_gnt, ext_rvalid, cpu_reset, mem_we, err;
    logic [31:0] ext_rdata, mem_adr, mem_wdata, mem_rdata, run_cycles;
    logic        start = 1'b0, halt = 1'b0, cpu_memwrite = 1'b0;
    logic [31:0] cpu_adr = '0, cpu_wdata = '0;
    logic [1:0]  state;
    logic [CW-1:0] load_count;

    dmem_load_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .start(start), .halt(halt), .cpu_reset(cpu_reset),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state(state), .load_count(load_count), .run_cycles(run_cycles), .err(err)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: combinational read, clocked write
    logic [31:0] dmem [256];
    assign mem_rdata = dmem[mem_adr[9:2]];
    always @(posedge clk) if (mem_we) dmem[mem_adr[9:2]] <= mem_wdata;

    // reference model
    logic [31:0] ref_mem [256];
    int          m_state;
    logic [31:0] m_run, m_rdata;
    int          m_load;
    bit          m_err, m_rv, m_crst, m_valid;
    int          vecs = 0, errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit st, input bit hl, input bit cw, input logic [31:0] ca,
                        input logic [31:0] cwd, input bit rn);
        bit host, al, g, w;
        logic [31:0] ad, d;
        int nx;
        ext_req = rq; ext_we = we; ext_addr = a; ext_wdata = wd;
        start = st; halt = hl; cpu_memwrite = cw; cpu_adr = ca; cpu_wdata = cwd; reset = rn;
        #4;
        host = m_state != 1;
        al   = a[1:0] == 2'b00;
        g    = rq && al && host;
        w    = host ? (rq && we && al) : cw;
        ad   = host ? a : ca;
        d    = host ? wd : cwd;
        if (m_valid) begin
            chk("ext_gnt", 32'(ext_gnt), 32'(g));
            chk("mem_we", 32'(mem_we), 32'(w));
            chk("mem_adr", mem_adr, ad);
            chk("mem_wdata", mem_wdata, d);
            chk("state", 32'(state), 32'(m_state));
            chk("cpu_reset", 32'(cpu_reset), 32'(m_crst));
            chk("load_count", 32'(load_count), 32'(m_load));
            chk("run_cycles", run_cycles, m_run);
            chk("err", 32'(err), 32'(m_err));
            chk("ext_rvalid", 32'(ext_rvalid), 32'(m_rv));
            chk("ext_rdata", ext_rdata, m_rdata);
        end
        m_rv = g && !we;
        if (m_rv) m_rdata = ref_mem[ad[9:2]];
        if (w) ref_mem[ad[9:2]] = d;
        if (g && we && m_load < (1 << CW) - 1) m_load++;
        if (rq && !al) m_err = 1;
        nx = m_state;
        if (m_state == 1) begin
            if (hl || (MAXC != 0 && m_run + 32'd1 == 32'(MAXC))) nx = 2;
        end else if (st) nx = 1;
        if (nx == 1 && m_state != 1) m_run = 0;
        else if (m_state == 1) m_run = m_run + 32'd1;
        m_state = nx;
        m_crst  = nx != 1;
        if (!rn) begin
            m_state = 0; m_crst = 1; m_rv = 0; m_rdata = 0;
            m_load = 0; m_run = 0; m_err = 0; m_valid = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hstep(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd);
        step(rq, we, a, wd, 0, 0, 0, 32'h300, 32'h0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        m_valid = 0; m_state = 0; m_run = 0; m_rdata = 0; m_load = 0;
        m_err = 0; m_rv = 0; m_crst = 1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hstep(0, 0, 0, 0);
        // preload two words while the CPU is held
        hstep(1, 1, 32'h10, 32'hDEADBEEF);
        hstep(1, 1, 32'h14, 32'h12345678);
        hstep(1, 0, 32'h10, 0);
        hstep(0, 0, 0, 0);
        chk("read_0x10", ext_rdata, 32'hDEADBEEF);
        chk("load_after_2", 32'(load_count), 32'd2);
        // misaligned write is refused and flags err
        hstep(1, 1, 32'h13, 32'h55555555);
        hstep(0, 0, 0, 0);
        chk("err_sticky", 32'(err), 32'd1);
        // start together with a host write: write lands, then RUN
        step(1, 1, 32'h18, 32'hA5A5A5A5, 1, 0, 0, 32'h300, 0, 1);
        step(1, 0, 32'h18, 0, 0, 0, 1, 32'h200, 32'hCAFE0001, 1);
        for (int i = 1; i < MAXC; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), 32'h20, $urandom,
                 0, 0, $urandom_range(0, 1), 32'h100 + 32'($urandom_range(0, 63)) * 4, $urandom, 1);
        chk("budget_halt_state", 32'(state), 32'd2);
        chk("budget_run_cycles", run_cycles, 32'd8);
        hstep(1, 0, 32'h200, 0);
        hstep(0, 0, 0, 0);
        chk("cpu_store_readback", ext_rdata, 32'hCAFE0001);
        // restart from HALT, explicit halt, then start+halt together
        step(0, 0, 0, 0, 1, 0, 0, 32'h300, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h204, 32'h77, 1);
        step(0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 32'h300, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 32'h300, 0, 1);
        hstep(0, 0, 0, 0);
        // reset in the middle of RUN
        step(0, 0, 0, 0, 1, 0, 0, 32'h300, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0);
        chk("reset_mid_run_state", 32'(state), 32'd0);
        hstep(1, 0, 32'h10, 0);
        hstep(0, 0, 0, 0);
        chk("post_reset_0x10", ext_rdata, 32'hDEADBEEF);
        // load_count saturation
        for (int i = 0; i < 20; i++)
            hstep(1, 1, 32'h40 + 32'(i) * 4, $urandom);
        hstep(0, 0, 0, 0);
        chk("load_saturated", 32'(load_count), 32'((1 << CW) - 1));
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            step($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1), 32'($urandom_range(0, 255)) * 4, $urandom,
                 $urandom_range(0, 60) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
